// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor: flag bit positions and op encodings.
package addsub_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/addsub_pipe_if.sv
// Issue/result handshake bundle between operand-issue logic, addsub_pipe and the result mux.
interface addsub_pipe_if
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    flags_t           out_flags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_flags, out_tag
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_flags, out_tag
    );

endinterface

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the carry chain; also exposes the carry into its top bit for overflow.
module addsub_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum      = total[CHUNK-1:0];
    assign cout     = total[CHUNK];
    // Carry into the top bit is recovered from the sum bit itself.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: STAGES registered carry-chain slices with a global stall and NZCV flags.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic [WIDTH-1:0] res_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [TAG_W-1:0] tag_d   [STAGES];
    logic [STAGES-1:0] cmsb_w;
    flags_t           flags_d;
    flags_t           flags_q;
    logic             advance;
    logic             unused_tail;

    assign advance      = !valid_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] pres;
        logic             pcin;
        logic             psub;
        logic             pv;
        logic [TAG_W-1:0] ptag;
        logic [CHUNK-1:0] sum;
        logic             cout;

        if (k == 0) begin : g_head
            assign pa   = bus.in_a;
            assign pb   = (bus.in_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
            assign pres = '0;
            assign pcin = bus.in_sub;
            assign psub = bus.in_sub;
            assign pv   = bus.in_valid;
            assign ptag = bus.in_tag;
        end else begin : g_body
            assign pa   = a_q[k-1];
            assign pb   = b_q[k-1];
            assign pres = res_q[k-1];
            assign pcin = carry_q[k-1];
            assign psub = sub_q[k-1];
            assign pv   = valid_q[k-1];
            assign ptag = tag_q[k-1];
        end

        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (pa[k*CHUNK +: CHUNK]),
            .b        (pb[k*CHUNK +: CHUNK]),
            .cin      (pcin),
            .sum      (sum),
            .cout     (cout),
            .c_msb_in (cmsb_w[k])
        );

        // Splice this slice's sum into its chunk; lower finished bits pass through untouched.
        assign res_d[k]   = (pres & ~(WIDTH'({CHUNK{1'b1}}) << (k*CHUNK)))
                          | (WIDTH'(sum) << (k*CHUNK));
        assign a_d[k]     = pa;
        assign b_d[k]     = pb;
        assign carry_d[k] = cout;
        assign sub_d[k]   = psub;
        assign valid_d[k] = pv;
        assign tag_d[k]   = ptag;
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = res_d[LAST][WIDTH-1];
        flags_d[FLAG_Z] = (res_d[LAST] == '0);
        flags_d[FLAG_C] = carry_d[LAST] ^ sub_d[LAST];
        flags_d[FLAG_V] = cmsb_w[LAST] ^ carry_d[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                res_q[s]   <= '0;
                carry_q[s] <= 1'b0;
                valid_q[s] <= 1'b0;
                sub_q[s]   <= 1'b0;
                tag_q[s]   <= '0;
            end
            flags_q <= '0;
        end else if (advance) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                a_q[s]     <= a_d[s];
                b_q[s]     <= b_d[s];
                res_q[s]   <= res_d[s];
                carry_q[s] <= carry_d[s];
                valid_q[s] <= valid_d[s];
                sub_q[s]   <= sub_d[s];
                tag_q[s]   <= tag_d[s];
            end
            flags_q <= flags_d;
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.out_res   = res_q[LAST];
    assign bus.out_flags = flags_q;
    assign bus.out_tag   = tag_q[LAST];

    // Final-stage operand/carry registers and lower slices' c_msb_in have no consumer.
    assign unused_tail = ^{cmsb_w, carry_q[LAST], sub_q[LAST], a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: directed flag cases, stall burst, mid-flight reset, random traffic.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;
    localparam int unsigned T = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic [T-1:0] tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    logic [S-1:0] sv;

    addsub_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

    addsub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic exp_t model(logic sub, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] tag);
        exp_t      e;
        logic [W:0] full;
        logic      c;
        logic      v;
        if (sub) begin
            full[W-1:0] = a - b;
            full[W]     = 1'b0;
            c           = (a < b);
            v           = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            c    = full[W];
            v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        e.res   = full[W-1:0];
        e.flags = {full[W-1], (full[W-1:0] == '0), c, v};
        e.tag   = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at the falling edge, update model, step.
    task automatic tick(output bit acc);
        logic adv_m;
        exp_t e;
        @(negedge clk);
        adv_m = !sv[S-1] || bus.out_ready;
        chk("out_valid", 64'(bus.out_valid), 64'(sv[S-1]));
        chk("in_ready", 64'(bus.in_ready), 64'(adv_m));
        if (sv[S-1] && sb.size() > 0) begin
            e = sb[0];
            chk("out_res", 64'(bus.out_res), 64'(e.res));
            chk("out_flags", 64'(bus.out_flags), 64'(e.flags));
            chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
            if (bus.out_ready) void'(sb.pop_front());
        end
        acc = bus.in_valid && adv_m;
        if (acc) sb.push_back(cur_exp);
        if (adv_m) sv = {sv[S-2:0], bus.in_valid};
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input logic [W-1:0] res, input logic [3:0] flags);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sub   = sub;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        cur_exp      = '{res: res, flags: flags, tag: tag};
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) tick(acc);
        bus.in_valid = 1'b0;
        for (int i = 0; i < S + 1; i++) tick(acc);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acc;
        int issued;
        int n_acc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sub    = OP_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        sv            = '0;
        cur_exp       = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset_out_res", 64'(bus.out_res), 64'(0));
        chk("reset_out_flags", 64'(bus.out_flags), 64'(0));
        chk("reset_out_tag", 64'(bus.out_tag), 64'(0));
        rst_n = 1'b1;

        issue(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 4'd3, 32'h0000_0100, 4'b0000);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd4, 32'h8000_0000, 4'b1001);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0000, 4'b0110);
        issue(OP_SUB, 32'd5,         32'd7,         4'd6, 32'hFFFF_FFFE, 4'b1010);
        issue(OP_SUB, 32'h8000_0000, 32'h0000_0001, 4'd7, 32'h7FFF_FFFF, 4'b0001);
        issue(OP_SUB, 32'd9,         32'd9,         4'd8, 32'h0000_0000, 4'b0100);

        // Eight back-to-back ops with the consumer stalling in cycles 3..5.
        issued = 0;
        for (int c = 0; c < 40 && (issued < 8 || sv != '0); c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            if (issued < 8) begin
                bus.in_valid = 1'b1;
                bus.in_sub   = issued[0];
                bus.in_a     = $urandom;
                bus.in_b     = $urandom;
                bus.in_tag   = T'(issued);
                cur_exp      = model(bus.in_sub, bus.in_a, bus.in_b, bus.in_tag);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick(acc);
            if (acc) issued++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("burst_issued", 64'(issued), 64'(8));
        chk("burst_drained", 64'(sb.size()), 64'(0));

        // Reset with three ops in flight, the oldest stalled at the output.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sub   = OP_ADD;
            bus.in_a     = 32'(i + 100);
            bus.in_b     = 32'd1;
            bus.in_tag   = T'(i + 9);
            cur_exp      = model(bus.in_sub, bus.in_a, bus.in_b, bus.in_tag);
            tick(acc);
        end
        bus.in_valid = 1'b0;
        repeat (2) tick(acc);
        chk("pre_reset_out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_res", 64'(bus.out_res), 64'(0));
        chk("rst_out_flags", 64'(bus.out_flags), 64'(0));
        chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
        sb.delete();
        sv = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (S + 4) tick(acc);

        // Random traffic with random back-pressure.
        n_acc = 0;
        for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_sub    = 1'($urandom_range(0, 1));
            bus.in_a      = rand_operand();
            bus.in_b      = rand_operand();
            bus.in_tag    = T'($urandom_range(0, 15));
            cur_exp       = model(bus.in_sub, bus.in_a, bus.in_b, bus.in_tag);
            tick(acc);
            if (acc) n_acc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (S + 2) tick(acc);
        chk("random_accepted", 64'(n_acc), 64'(10000));
        chk("random_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
